// File: rtl/spi_master_pkg.sv
// Shared encodings, widths and FSM state type for the SPI master controller.
// The frame on the wire is {op, data}, sent MSB first.
package spi_master_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned RX_BITS    = 8;
    localparam int unsigned CNT_BITS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEL,
        SHIFT,
        WAIT,
        RECV,
        END
    } state_e;

    // Only read-data frames turn the line around and return a byte.
    function automatic logic op_has_rsp(input logic [1:0] op);
        return op == OP_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command/response bus between a requester and the SPI master controller.
// The requester uses the master modport, the controller the slave modport.
interface spi_master_ctrl_if;
    import spi_master_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [RX_BITS-1:0]    cmd_data;
    logic                  rsp_valid;
    logic [RX_BITS-1:0]    rsp_data;
    logic                  busy;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output busy
    );

endinterface

// File: rtl/spi_master_shreg.sv
// Loadable parallel-in/serial-out frame register for MOSI plus a serial-in
// capture register for MISO; the FSM owns all the enables.
module spi_master_shreg
    import spi_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_frame,
    input  logic                  shift,
    input  logic                  capture,
    input  logic                  miso,
    output logic                  tx_msb,
    output logic [RX_BITS-1:0]    rx_data
);

    logic [FRAME_BITS-1:0] tx_q;
    logic [RX_BITS-1:0]    rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load) begin
                tx_q <= load_frame;
            end else if (shift) begin
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            // Captured byte is the response itself, so it holds between reads.
            if (capture) begin
                rx_q <= {rx_q[RX_BITS-2:0], miso};
            end
        end
    end

    assign tx_msb  = tx_q[FRAME_BITS-1];
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master that turns one accepted RAM command into one slave frame and,
// for read-data commands, returns the byte clocked in on MISO.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned GAP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave cmd,
    output logic             ss_n,
    output logic             MOSI,
    input  logic             MISO
);

    localparam logic [CNT_BITS-1:0] SHIFT_LOAD = CNT_BITS'(FRAME_BITS - 1);
    localparam logic [CNT_BITS-1:0] RECV_LOAD  = CNT_BITS'(RX_BITS - 1);
    localparam logic [CNT_BITS-1:0] WAIT_LOAD  = CNT_BITS'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
    localparam logic [CNT_BITS-1:0] END_LOAD   = CNT_BITS'(GAP - 1);

    state_e                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  rd_q;
    logic                  ss_n_q;
    logic                  mosi_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  rsp_valid_q;

    logic                  accept;
    logic                  shift;
    logic                  capture;
    logic                  tx_msb;
    logic [FRAME_BITS-1:0] frame;
    logic [RX_BITS-1:0]    rx_data;

    assign accept  = (state_q == IDLE) && ready_q && cmd.cmd_valid;
    assign frame   = {cmd.cmd_op, cmd.cmd_data};
    // Shifting already in SEL puts frame bit 9 on MOSI in the first SHIFT cycle.
    assign shift   = (state_q == SEL) || (state_q == SHIFT);
    assign capture = (state_q == RECV);

    spi_master_shreg u_shreg (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_frame (frame),
        .shift      (shift),
        .capture    (capture),
        .miso       (MISO),
        .tx_msb     (tx_msb),
        .rx_data    (rx_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        state_q <= START;
                        rd_q    <= op_has_rsp(cmd.cmd_op);
                        ss_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    // Frame bit 9 is op[1], the slave's read/write branch bit.
                    state_q <= SEL;
                    mosi_q  <= tx_msb;
                end
                SEL: begin
                    state_q <= SHIFT;
                    mosi_q  <= tx_msb;
                    cnt_q   <= SHIFT_LOAD;
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        mosi_q <= 1'b0;
                        if (rd_q) begin
                            state_q <= (RD_WAIT == 0) ? RECV : WAIT;
                            cnt_q   <= (RD_WAIT == 0) ? RECV_LOAD : WAIT_LOAD;
                        end else begin
                            state_q <= END;
                            ss_n_q  <= 1'b1;
                            cnt_q   <= END_LOAD;
                        end
                    end else begin
                        mosi_q <= tx_msb;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RECV;
                        cnt_q   <= RECV_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RECV: begin
                    if (cnt_q == '0) begin
                        state_q     <= END;
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= END_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                END: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ss_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.busy      = busy_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rx_data;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-clock SPI master that drives the team's SPI slave/RAM wrapper through its ss_n/MOSI/MISO pins.
- Accepts one RAM command per valid/ready handshake: write address, write data, read address or read data.
- Serialises each command into the slave's frame format and, for read-data, captures the returned byte.
- Sits directly upstream of the slave wrapper, replacing hand-driven testbench stimulus with synthesisable frame generation.

## Interface
Parameters:
- RD_WAIT, 2: cycles between the last command bit and the first MISO sample on read-data frames (0 legal).
- GAP, 1: minimum cycles ss_n is held high after each frame (>=1).

Ports:
- clk  in  1  system clock; the same clock feeds the slave. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- cmd_data  in  8  address or write byte; a dummy value for op 11, transmitted unchanged.
- rsp_valid  out  1  one-cycle pulse when a read-data byte is captured.
- rsp_data  out  8  captured byte; holds until the next capture.
- busy  out  1  high in every state except IDLE.
- ss_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

## Operation
- All outputs are registered.
- Reset values: ss_n=1, MOSI=0, cmd_ready=0 while rst=1, rsp_valid=0, rsp_data=8'h00, busy=0.
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. cmd_op and cmd_data are latched into a 10-bit frame {cmd_op, cmd_data}.
- FSM states and transitions:
  - IDLE: ss_n=1, MOSI=0. On accept -> START.
  - START: 1 cycle; ss_n=0, MOSI=0.
  - SEL: 1 cycle; MOSI=cmd_op[1], the slave's read/write branch bit.
  - SHIFT: 10 cycles; MOSI = frame[9] down to frame[0], MSB first. Then -> WAIT if op==11, else -> END.
  - WAIT: RD_WAIT cycles; MOSI=0, ss_n=0. If RD_WAIT=0, go straight to RECV.
  - RECV: 8 cycles; MISO is sampled on each closing edge into rsp_data, MSB first.
  - END: GAP cycles; ss_n=1, MOSI=0.
    - If END was entered from RECV, rsp_valid pulses in the first END cycle.
    - After GAP cycles -> IDLE.
- Frame length with ss_n low: 12 cycles for ops 00/01/10; 20+RD_WAIT cycles for op 11.
- cmd_valid is ignored while busy.
- Reset mid-frame: at the next edge ss_n=1, MOSI=0, FSM=IDLE. No rsp_valid is produced and rsp_data is cleared to 0.
- rst takes priority over a simultaneous cmd_valid.

## Timing
- Accept edge T: ss_n=0 from T+1 (START), MOSI=op[1] from T+2, frame bit 9 from T+3, bit 0 from T+12.
- Ops 00/01/10: ss_n returns high at T+13.
- Op 11: the first MISO sample is the edge ending cycle T+13+RD_WAIT. rsp_valid is high in cycle T+21+RD_WAIT, the same cycle ss_n returns high.
- With cmd_valid held high continuously, ss_n is high for exactly GAP+1 cycles between frames: GAP cycles in END plus 1 cycle in IDLE.
- The bit counter is 4 bits wide and reloaded on every state entry; no wrap-around is used.

## Structure
- Package spi_master_pkg holds:
  - op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_BITS=10 and RX_BITS=8;
  - the state enum {IDLE, START, SEL, SHIFT, WAIT, RECV, END}.
- One sub-module: spi_master_shreg, a loadable 10-bit parallel-in/serial-out shift register for MOSI combined with an 8-bit serial-in capture for MISO, driven by shift/load/capture enables from the FSM.

## Test plan
1. Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> ss_n=1, MOSI=0, cmd_ready=0, rsp_valid=0. cmd_ready=1 on the first cycle after release.
2. Write address, op=00, data=8'h77 -> ss_n low exactly 12 cycles with MOSI sequence 0,0,0,0,0,1,1,1,0,1,1,1, then ss_n=1.
3. Write data, op=01, data=8'hAA -> ss_n low 12 cycles with MOSI sequence 0,0,0,1,1,0,1,0,1,0,1,0; rsp_valid never asserts.
4. Read data, op=11, RD_WAIT=2, slave model drives 8'hA5 MSB first in RECV -> ss_n low 22 cycles, a single rsp_valid pulse with rsp_data=8'hA5.
5. cmd_valid held high for four commands (00/77, 01/AA, 10/77, 11/00) -> four frames, ss_n high exactly GAP+1=2 cycles between frames, one rsp_valid total.
6. rst pulsed during SHIFT bit 5 of an op-11 frame -> ss_n=1 and MOSI=0 next cycle, no rsp_valid, rsp_data=0; a following op-00 command produces a correct 12-cycle frame.
